// File: rtl/mipi_tx_pkg.sv
// Shared types and helpers for the MIPI TX packet arbiter.
//   tx_state_e  : arbiter FSM states
//   DT_*        : DSI data-type codes seen on the TX command path
//   is_long_dt  : long/short packet classification from the data type
package mipi_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_PAYLOAD = 2'd2
  } tx_state_e;

  localparam logic [5:0] DT_VSS       = 6'h01;
  localparam logic [5:0] DT_VSE       = 6'h11;
  localparam logic [5:0] DT_HSS       = 6'h21;
  localparam logic [5:0] DT_RGB888    = 6'h3E;
  localparam logic [5:0] DT_DCS_LONG  = 6'h39;
  localparam logic [5:0] DT_DCS_SHORT = 6'h05;

  // Width of the host-ack timeout counter.
  localparam int TMO_W = 13;

  // Long packets carry a payload; the low nibble of the data type decides.
  function automatic logic is_long_dt(input logic [5:0] dt);
    logic res;
    case (dt[3:0])
      4'h9, 4'hC, 4'hD, 4'hE: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mipi_tx_pkt_arbiter_aging.sv
// Aux aging counter.
// Counts cycles a request is pending without being served, saturating at
// MAX_WAIT. expired is high once the count has reached MAX_WAIT.
//   clktx, rst : clock, async active-high reset
//   req        : request pending
//   clr        : request served / currently being served
//   expired    : wait count >= MAX_WAIT
module mipi_tx_aging_ctr #(
  parameter int unsigned MAX_WAIT = 512
) (
  input  logic clktx,
  input  logic rst,
  input  logic req,
  input  logic clr,
  output logic expired
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX_WAIT);

  logic [W-1:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (!req || clr)          wait_d = '0;
    else if (wait_q != MAX_V) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clktx or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end

  assign expired = (wait_q >= MAX_V);

endmodule

// File: rtl/mipi_tx_pkt_arbiter.sv
// Two-source arbiter for the MIPI host TX packet interface.
// Video (v_*) has strict priority; aux (a_*) wins a packet boundary once it
// has waited AUX_MAX_WAIT cycles. Packets are atomic: ownership is fixed at
// grant and held through the command handshake and the payload phase.
// Ports:
//   clktx, rst              : clock, async active-high reset
//   v_* / a_*               : requester command fields, ack, payload strobes
//   host_req / host_ack     : command handshake toward the host TX
//   host_tx_cmd_*           : command fields of the current owner
//   host_tx_payload_en/_last: host payload strobes, routed to the owner
//   host_tx_payload         : owner payload word
//   sel_aux, busy           : owner (1 = aux), arbiter not idle
//   ack_timeout_err, clr_err: sticky host-ack timeout flag and its clear
//   aux_grant_cnt           : wrapping number of aux grants
module mipi_tx_pkt_arbiter
  import mipi_tx_pkg::*;
#(
  parameter int unsigned AUX_MAX_WAIT = 512,
  parameter int unsigned ACK_TIMEOUT  = 4096
) (
  input  logic        clktx,
  input  logic        rst,
  // video source
  input  logic        v_req,
  input  logic [1:0]  v_vc,
  input  logic [5:0]  v_dt,
  input  logic [15:0] v_wc,
  input  logic        v_hs,
  output logic        v_ack,
  output logic        v_payload_en,
  output logic        v_payload_en_last,
  input  logic [31:0] v_payload,
  // aux source
  input  logic        a_req,
  input  logic [1:0]  a_vc,
  input  logic [5:0]  a_dt,
  input  logic [15:0] a_wc,
  input  logic        a_hs,
  output logic        a_ack,
  output logic        a_payload_en,
  output logic        a_payload_en_last,
  input  logic [31:0] a_payload,
  // host TX
  output logic        host_req,
  input  logic        host_ack,
  output logic [1:0]  host_tx_cmd_vc,
  output logic [5:0]  host_tx_cmd_data_type,
  output logic [15:0] host_tx_cmd_byte_count,
  output logic        host_tx_hs_mode,
  input  logic        host_tx_payload_en,
  input  logic        host_tx_payload_en_last,
  output logic [31:0] host_tx_payload,
  // status
  output logic        sel_aux,
  output logic        busy,
  output logic        ack_timeout_err,
  input  logic        clr_err,
  output logic [15:0] aux_grant_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  tx_state_e         state_q, state_d;
  logic              sel_aux_q, sel_aux_d;
  logic              host_req_q, host_req_d;
  logic              err_q, err_d;
  logic              long_q, long_d;
  logic [15:0]       grant_cnt_q, grant_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic grant_aux, grant_any, aux_expired, aux_age_clr, busy_w;

  assign busy_w    = (state_q != ST_IDLE);
  assign grant_any = v_req | a_req;
  assign grant_aux = a_req & (~v_req | aux_expired);

  // Aux stops aging while it is being granted or already owns the port.
  assign aux_age_clr = ((state_q == ST_IDLE) & grant_aux) | (busy_w & sel_aux_q);

  mipi_tx_aging_ctr #(
    .MAX_WAIT (AUX_MAX_WAIT)
  ) u_aux_age (
    .clktx   (clktx),
    .rst     (rst),
    .req     (a_req),
    .clr     (aux_age_clr),
    .expired (aux_expired)
  );

  always_comb begin
    state_d     = state_q;
    sel_aux_d   = sel_aux_q;
    host_req_d  = host_req_q;
    err_d       = err_q;
    long_d      = long_q;
    grant_cnt_d = grant_cnt_q;
    tmo_d       = tmo_q;

    // A timeout set later in this block overrides the clear.
    if (clr_err) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          state_d    = ST_REQ;
          host_req_d = 1'b1;
          sel_aux_d  = grant_aux;
          tmo_d      = '0;
          // Classify from the fields presented at grant; the owner holds
          // them stable until its ack.
          long_d     = grant_aux ? (is_long_dt(a_dt) && (a_wc != 16'd0))
                                 : (is_long_dt(v_dt) && (v_wc != 16'd0));
          if (grant_aux) grant_cnt_d = grant_cnt_q + 16'd1;
        end
      end
      ST_REQ: begin
        if (host_ack) begin
          host_req_d = 1'b0;
          state_d    = long_q ? ST_PAYLOAD : ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          host_req_d = 1'b0;
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (host_tx_payload_en_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clktx or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_aux_q   <= 1'b0;
      host_req_q  <= 1'b0;
      err_q       <= 1'b0;
      long_q      <= 1'b0;
      grant_cnt_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_aux_q   <= sel_aux_d;
      host_req_q  <= host_req_d;
      err_q       <= err_d;
      long_q      <= long_d;
      grant_cnt_q <= grant_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign host_req        = host_req_q;
  assign sel_aux         = sel_aux_q;
  assign busy            = busy_w;
  assign ack_timeout_err = err_q;
  assign aux_grant_cnt   = grant_cnt_q;

  assign host_tx_cmd_vc         = sel_aux_q ? a_vc : v_vc;
  assign host_tx_cmd_data_type  = sel_aux_q ? a_dt : v_dt;
  assign host_tx_cmd_byte_count = sel_aux_q ? a_wc : v_wc;
  assign host_tx_hs_mode        = sel_aux_q ? a_hs : v_hs;
  assign host_tx_payload        = sel_aux_q ? a_payload : v_payload;

  assign v_ack = host_req_q & host_ack & ~sel_aux_q;
  assign a_ack = host_req_q & host_ack &  sel_aux_q;

  // Strobes reach only the owner, and only while a packet is in flight
  // (an ack-cycle strobe in REQ is forwarded too).
  assign v_payload_en      = host_tx_payload_en      & busy_w & ~sel_aux_q;
  assign v_payload_en_last = host_tx_payload_en_last & busy_w & ~sel_aux_q;
  assign a_payload_en      = host_tx_payload_en      & busy_w &  sel_aux_q;
  assign a_payload_en_last = host_tx_payload_en_last & busy_w &  sel_aux_q;

endmodule
